// File: rtl/nibble_serial_adder.sv
// Nibble-serial multi-word adder controller: streams operand nibbles LSB first
// through an external 4-bit adder and assembles the full-width sum and carry.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [4*NIBBLES-1:0] i_a_in,
    input  logic [4*NIBBLES-1:0] i_b_in,
    input  logic                 i_cin,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [4*NIBBLES-1:0] o_sum,
    output logic                 o_cout,
    output logic [3:0]           o_add_a,
    output logic [3:0]           o_add_b,
    output logic                 o_add_c0,
    input  logic [3:0]           i_add_s,
    input  logic                 i_add_c4
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic            r_cout;
    logic            r_busy;
    logic            r_done;
    logic [IW-1:0]   r_idx;
    logic [3:0]      r_sum_nib [NIBBLES];
    logic [3:0]      w_a_nib   [NIBBLES];
    logic [3:0]      w_b_nib   [NIBBLES];
    logic            w_accept;
    logic            w_in_busy;

    assign w_accept  = (r_state == ST_IDLE) && i_start;
    assign w_in_busy = (r_state == ST_BUSY);

    // Per-slice operand views and sum slices; each slice is written only when idx selects it.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_slice
            assign w_a_nib[gi] = r_a[4*gi +: 4];
            assign w_b_nib[gi] = r_b[4*gi +: 4];
            assign o_sum[4*gi +: 4] = r_sum_nib[gi];

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_sum_nib[gi] <= 4'h0;
                end else if (w_accept) begin
                    r_sum_nib[gi] <= 4'h0;
                end else if (w_in_busy && (r_idx == IW'(gi))) begin
                    r_sum_nib[gi] <= i_add_s;
                end
            end
        end
    endgenerate

    // Adder-facing drive is combinational so the adder result returns in the same cycle.
    always_comb begin
        o_add_a  = 4'h0;
        o_add_b  = 4'h0;
        o_add_c0 = 1'b0;
        if (w_in_busy) begin
            o_add_c0 = r_carry;
            for (int n = 0; n < NIBBLES; n++) begin
                if (r_idx == IW'(n)) begin
                    o_add_a = w_a_nib[n];
                    o_add_b = w_b_nib[n];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a     <= i_a_in;
                        r_b     <= i_b_in;
                        r_carry <= i_cin;
                        r_cout  <= 1'b0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_carry <= i_add_c4;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= i_add_c4;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_cout = r_cout;

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Nibble-serial multi-word adder controller that sits directly in front of and behind the `adder_4bits` stage. It accepts two `4*NIBBLES`-bit operands and a carry-in, and presents one nibble pair per cycle to an external 4-bit adder, least significant nibble first. It captures each 4-bit sum and chains the adder's carry-out back into its carry-in on the next cycle. When finished, it reports the full-width sum and final carry-out with a one-cycle done pulse.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices. Operand width is `W = 4*NIBBLES`. Legal range is 1..16.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to begin an addition. Sampled only in IDLE.
- `a_in`  in  W  operand A. Sampled on the accepting edge.
- `b_in`  in  W  operand B. Sampled on the accepting edge.
- `cin`  in  1  carry-in. Sampled on the accepting edge.
- `busy`  out  1  high while in BUSY or DONE.
- `done`  out  1  one-cycle pulse; `sum`/`cout` are valid.
- `sum`  out  W  registered result.
- `cout`  out  1  registered final carry-out.
- `add_a`  out  4  nibble of A to the adder's `A`.
- `add_b`  out  4  nibble of B to the adder's `B`.
- `add_c0`  out  1  chained carry to the adder's `C0`.
- `add_s`  in  4  from the adder's `S`. Combinational response within the same cycle.
- `add_c4`  in  1  from the adder's `C4`.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, with `start`=1 at an edge:
  - latch `a_in`/`b_in` into operand registers and `cin` into the carry register;
  - clear `sum` and `cout`;
  - set the nibble index `idx` to 0;
  - go to BUSY.
- IDLE, with `start`=0: stay in IDLE.
- BUSY, combinational drive:
  - `add_a` = `A[4*idx+3:4*idx]`;
  - `add_b` = `B[4*idx+3:4*idx]`;
  - `add_c0` = carry register.
- BUSY, each edge:
  - `sum[4*idx+3:4*idx]` <= `add_s`;
  - carry register <= `add_c4`;
  - if `idx` = NIBBLES-1, then `cout` <= `add_c4` and go to DONE; otherwise `idx` <= `idx`+1.
- DONE: `done`=1 for exactly this cycle, then return to IDLE unconditionally.
- `start` asserted in BUSY or DONE is ignored. It is not queued.
- In IDLE and DONE, `add_a`, `add_b` and `add_c0` are driven to 0.
- `sum` and `cout` hold their last value until the next accepted `start`.
- `idx` width is `$clog2(NIBBLES)` bits, with a minimum of 1 bit. `idx` never exceeds NIBBLES-1.
- Arithmetic is unsigned modulo 2^W. Overflow is reported only through `cout`.

## Timing
- Reset (async assert, sync release) forces:
  - state to IDLE;
  - `busy`=0, `done`=0;
  - `sum`=0, `cout`=0;
  - `add_a`=0, `add_b`=0, `add_c0`=0;
  - all internal registers to 0.
- Reset asserted mid-operation aborts the addition and no `done` is produced.
- Timing for a `start` accepted at edge k:
  - BUSY occupies cycles k+1 .. k+NIBBLES;
  - `done` is high in cycle k+NIBBLES+1;
  - latency is NIBBLES+1 cycles from the accepting edge to the `done` cycle.
- The earliest next accept is the edge that ends the cycle after DONE. That gives a throughput of one addition per NIBBLES+2 cycles.
- `busy` rises in the cycle after the accepting edge and falls in the cycle after DONE.
- The adder path is purely combinational within one cycle. Timing closure covers `add_*` out -> `adder_4bits` -> `add_s`/`add_c4` in.
- Operand inputs may change freely after the accepting edge without affecting the result.

## Test plan
- NIBBLES=4: `a_in`=16'h1234, `b_in`=16'h1111, `cin`=0, `start` pulse.
  - Required: `sum`=16'h2345, `cout`=0.
  - `done` is a single-cycle pulse exactly 5 cycles after the accepting edge.
  - `add_a` sequence is 4,3,2,1.
- `a_in`=16'hFFFF, `b_in`=16'h0001, `cin`=0.
  - Required: `sum`=16'h0000, `cout`=1.
  - `add_c0` sequence is 0,1,1,1 (carry chains across every nibble).
- `a_in`=16'hFFFF, `b_in`=16'hFFFF, `cin`=1.
  - Required: `sum`=16'hFFFF, `cout`=1.
- Start 16'h0F0F+16'h0101; during BUSY, re-assert `start` with different operands.
  - Required: the second request is ignored, `sum`=16'h1010, and only one `done` pulse occurs.
- Assert `reset` in the 2nd BUSY cycle.
  - Required: all outputs are 0 immediately (asynchronous) and no `done` follows.
  - A fresh 16'h0001+16'h0001 after release gives `sum`=16'h0002.
- Back-to-back runs: 16'h8000+16'h8000 then 16'h0003+16'h0004, with `start` held high.
  - Required: results 16'h0000/`cout`=1, then 16'h0007/`cout`=0.
  - The second accept happens at the edge ending the cycle after DONE.
